alu_ctrl_unit: RTL and testbench

//  MIPS-subset execute block: decodes OpCode/Funct into ALUFun and Sign, then

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_ctrl_unit_core.sv | 86 ++++++++
 rtl/alu_ctrl_unit.sv | 69 ++++++
 tb/tb_alu_ctrl_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU function codes plus MIPS OpCode/Funct constants
// shared by the decoder and the datapath.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110010;
  localparam logic [5:0] ALU_NEQ   = 6'b110000;
  localparam logic [5:0] ALU_LT    = 6'b110100;
  localparam logic [5:0] ALU_LEZ   = 6'b111100;
  localparam logic [5:0] ALU_LTZ   = 6'b111010;
  localparam logic [5:0] ALU_GTZ   = 6'b111110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage

// File: rtl/alu_ctrl_unit_core.sv
// Combinational ALU: (ALUFun, Sign, A, B) -> result.
// Ports: alu_fun, sign, a, b in; result out.
module alu_core
  import alu_pkg::*;
(
  input  logic [5:0]  alu_fun,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] sum;
  logic [32:0] diff;
  logic        a_zero;
  logic        lt;
  logic        cmp;
  logic [4:0]  sh;
  logic [31:0] arith_r;
  logic [31:0] logic_r;
  logic [31:0] shift_r;

  assign sum    = a + b;
  assign diff   = {1'b0, a} - {1'b0, b};
  assign a_zero = (a == 32'd0);
  assign sh     = a[4:0];

  // diff[32] is the borrow out of A-B
  assign lt = sign ? ((a[31] != b[31]) ? a[31] : diff[31])
                   : diff[32];

  always_comb begin
    arith_r = 32'd0;
    case (alu_fun[3:0])
      4'b0000: arith_r = sum;
      4'b0001: arith_r = diff[31:0];
      default: arith_r = 32'd0;
    endcase
  end

  always_comb begin
    logic_r = 32'd0;
    case (alu_fun[3:0])
      4'b1000: logic_r = a & b;
      4'b1110: logic_r = a | b;
      4'b0110: logic_r = a ^ b;
      4'b0001: logic_r = ~(a | b);
      4'b1010: logic_r = a;
      default: logic_r = 32'd0;
    endcase
  end

  always_comb begin
    shift_r = 32'd0;
    case (alu_fun[1:0])
      2'b00:   shift_r = b << sh;
      2'b01:   shift_r = b >> sh;
      2'b11:   shift_r = $unsigned($signed(b) >>> sh);
      default: shift_r = 32'd0;
    endcase
  end

  always_comb begin
    cmp = 1'b0;
    case (alu_fun[3:1])
      3'b001:  cmp = (a == b);
      3'b000:  cmp = (a != b);
      3'b010:  cmp = lt;
      3'b110:  cmp = a[31] | a_zero;
      3'b101:  cmp = a[31];
      3'b111:  cmp = ~a[31] & ~a_zero;
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    result = 32'd0;
    case (alu_fun[5:4])
      2'b00:   result = arith_r;
      2'b01:   result = logic_r;
      2'b10:   result = shift_r;
      default: result = {31'd0, cmp};
    endcase
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// EX-stage ALU: decodes OpCode/Funct to ALUFun/Sign, registers result Z.
// Ports: clk, reset (async low), OpCode, Funct, A, B in; ALUFun, Sign, Z out.
module alu_ctrl_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic [31:0] Z
);

  logic [31:0] result;

  always_comb begin
    ALUFun = ALU_ADD;
    Sign   = 1'b1;
    if (OpCode == OP_RTYPE) begin
      case (Funct)
        FN_ADD:  ALUFun = ALU_ADD;
        FN_ADDU: begin ALUFun = ALU_ADD; Sign = 1'b0; end
        FN_SUB:  ALUFun = ALU_SUB;
        FN_SUBU: begin ALUFun = ALU_SUB; Sign = 1'b0; end
        FN_AND:  ALUFun = ALU_AND;
        FN_OR:   ALUFun = ALU_OR;
        FN_XOR:  ALUFun = ALU_XOR;
        FN_NOR:  ALUFun = ALU_NOR;
        FN_SLT:  ALUFun = ALU_LT;
        FN_SLTU: begin ALUFun = ALU_LT; Sign = 1'b0; end
        FN_SLL:  ALUFun = ALU_SLL;
        FN_SRL:  ALUFun = ALU_SRL;
        FN_SRA:  ALUFun = ALU_SRA;
        default: ALUFun = ALU_ADD;
      endcase
    end else begin
      // lw/sw/lui fall through to the ADD default
      case (OpCode)
        OP_ADDIU: begin ALUFun = ALU_ADD; Sign = 1'b0; end
        OP_ANDI:  ALUFun = ALU_AND;
        OP_SLTI:  ALUFun = ALU_LT;
        OP_SLTIU: begin ALUFun = ALU_LT; Sign = 1'b0; end
        OP_BEQ:   ALUFun = ALU_EQ;
        OP_BNE:   ALUFun = ALU_NEQ;
        OP_BLEZ:  ALUFun = ALU_LEZ;
        OP_BGTZ:  ALUFun = ALU_GTZ;
        OP_BLTZ:  ALUFun = ALU_LTZ;
        default:  ALUFun = ALU_ADD;
      endcase
    end
  end

  alu_core u_core (
    .alu_fun (ALUFun),
    .sign    (Sign),
    .a       (A),
    .b       (B),
    .result  (result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Z <= 32'd0;
    else        Z <= result;
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with an expected-result queue.
// Decode outputs are checked combinationally, Z one clock later.
module tb_alu_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] Z;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_ctrl_unit dut (
    .clk    (clk),
    .reset  (reset),
    .OpCode (OpCode),
    .Funct  (Funct),
    .A      (A),
    .B      (B),
    .ALUFun (ALUFun),
    .Sign   (Sign),
    .Z      (Z)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op,
                     input logic [5:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    OpCode = op; Funct = fn; A = a; B = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, Z, e);
  endtask

  task automatic dec(input logic [5:0] op, input logic [5:0] fn,
                     input logic [5:0] efun, input logic es);
    OpCode = op; Funct = fn;
    #1;
    chk($sformatf("dec %h/%h fun", op, fn), {26'd0, ALUFun},
        {26'd0, efun});
    chk($sformatf("dec %h/%h sign", op, fn), {31'd0, Sign},
        {31'd0, es});
  endtask

  initial begin
    reset = 1'b0;
    OpCode = 6'h00; Funct = 6'h20; A = 32'd3; B = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Z", Z, 32'd0);

    // first result one clock after release
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'd8);
    @(posedge clk);
    #1;
    chk("first add", Z, exp_q.pop_front());

    run("addu", 6'h00, 6'h21, 32'h3, 32'hfffffffb, 32'hfffffffe);
    run("addi", 6'h08, 6'h3f, 32'hfffffffb, 32'hfffffffd, 32'hfffffff8);
    run("addiu wrap", 6'h09, 6'h00, 32'h7fffffff, 32'h5, 32'h80000004);
    run("sub", 6'h00, 6'h22, 32'h3, 32'hfffffffb, 32'h8);
    run("subu", 6'h00, 6'h23, 32'h5, 32'h7, 32'hfffffffe);

    run("and", 6'h00, 6'h24, 32'ha85e9cd0, 32'h2ec90029, 32'h28480000);
    run("or", 6'h00, 6'h25, 32'ha85e9cd0, 32'h2ec90029, 32'haedf9cf9);
    run("xor", 6'h00, 6'h26, 32'ha85e9cd0, 32'h2ec90029, 32'h86979cf9);
    run("nor", 6'h00, 6'h27, 32'ha85e9cd0, 32'h2ec90029, 32'h51206306);
    run("andi", 6'h0c, 6'h25, 32'ha85e9cd0, 32'h2ec90029, 32'h28480000);

    run("sll 5", 6'h00, 6'h00, 32'h5, 32'hea6c50bb, 32'h4d8a1760);
    run("srl 5", 6'h00, 6'h02, 32'h5, 32'hea6c50bb, 32'h07536285);
    run("sra 5", 6'h00, 6'h03, 32'h5, 32'hea6c50bb, 32'hff536285);
    run("sll 27", 6'h00, 6'h00, 32'hfffffffb, 32'hea6c50bb, 32'hd8000000);
    run("sra 27", 6'h00, 6'h03, 32'hfffffffb, 32'hea6c50bb, 32'hfffffffd);
    run("sra pos", 6'h00, 6'h03, 32'h5, 32'h6a6c50bb, 32'h03536285);
    run("srl hi bits", 6'h00, 6'h02, 32'hffffffe1, 32'h80000000,
        32'h40000000);

    run("slt", 6'h00, 6'h2a, 32'h3, 32'hfffffffb, 32'h0);
    run("sltu", 6'h00, 6'h2b, 32'h3, 32'hfffffffb, 32'h1);
    run("slti neg", 6'h0a, 6'h00, 32'hfffffffb, 32'h3, 32'h1);
    run("sltiu", 6'h0b, 6'h00, 32'hfffffffb, 32'h3, 32'h0);
    run("slt same sign", 6'h00, 6'h2a, 32'hfffffff0, 32'hfffffff8, 32'h1);
    run("beq eq", 6'h04, 6'h00, 32'h1234, 32'h1234, 32'h1);
    run("beq ne", 6'h04, 6'h00, 32'h1234, 32'h1235, 32'h0);
    run("bne eq", 6'h05, 6'h00, 32'h1234, 32'h1234, 32'h0);
    run("bne ne", 6'h05, 6'h00, 32'h1234, 32'h0, 32'h1);
    run("blez 0", 6'h06, 6'h00, 32'h0, 32'h9, 32'h1);
    run("blez pos", 6'h06, 6'h00, 32'h1, 32'h9, 32'h0);
    run("bgtz neg", 6'h07, 6'h00, 32'hc672e58a, 32'h0, 32'h0);
    run("bgtz pos", 6'h07, 6'h00, 32'h7, 32'h0, 32'h1);
    run("bgtz 0", 6'h07, 6'h00, 32'h0, 32'h0, 32'h0);
    run("bltz neg", 6'h01, 6'h00, 32'hc672e58a, 32'h0, 32'h1);
    run("bltz pos", 6'h01, 6'h00, 32'h7, 32'h0, 32'h0);
    run("lui", 6'h0f, 6'h00, 32'h0, 32'habcd0000, 32'habcd0000);
    run("lw", 6'h23, 6'h00, 32'h1000, 32'h10, 32'h1010);
    run("jr", 6'h00, 6'h08, 32'h40, 32'h4, 32'h44);
    run("op 3f", 6'h3f, 6'h22, 32'h1, 32'h2, 32'h3);

    // async reset between edges clears Z at once
    run("pre reset", 6'h00, 6'h20, 32'h11, 32'h22, 32'h33);
    #2;
    reset = 1'b0;
    #1;
    chk("async clear", Z, 32'd0);
    @(posedge clk);
    #1;
    chk("held clear", Z, 32'd0);
    @(negedge clk);
    OpCode = 6'h00; Funct = 6'h20; A = 32'h10; B = 32'h20;
    reset = 1'b1;
    #1;
    chk("no early Z", Z, 32'd0);
    @(posedge clk);
    #1;
    chk("post reset", Z, 32'h30);

    @(negedge clk);
    dec(6'h00, 6'h20, 6'b000000, 1'b1);
    dec(6'h00, 6'h21, 6'b000000, 1'b0);
    dec(6'h00, 6'h22, 6'b000001, 1'b1);
    dec(6'h00, 6'h23, 6'b000001, 1'b0);
    dec(6'h00, 6'h24, 6'b011000, 1'b1);
    dec(6'h00, 6'h25, 6'b011110, 1'b1);
    dec(6'h00, 6'h26, 6'b010110, 1'b1);
    dec(6'h00, 6'h27, 6'b010001, 1'b1);
    dec(6'h00, 6'h2a, 6'b110100, 1'b1);
    dec(6'h00, 6'h2b, 6'b110100, 1'b0);
    dec(6'h00, 6'h00, 6'b100000, 1'b1);
    dec(6'h00, 6'h02, 6'b100001, 1'b1);
    dec(6'h00, 6'h03, 6'b100011, 1'b1);
    dec(6'h00, 6'h09, 6'b000000, 1'b1);
    dec(6'h08, 6'h21, 6'b000000, 1'b1);
    dec(6'h09, 6'h20, 6'b000000, 1'b0);
    dec(6'h23, 6'h24, 6'b000000, 1'b1);
    dec(6'h2b, 6'h2b, 6'b000000, 1'b1);
    dec(6'h0f, 6'h00, 6'b000000, 1'b1);
    dec(6'h0c, 6'h27, 6'b011000, 1'b1);
    dec(6'h0a, 6'h00, 6'b110100, 1'b1);
    dec(6'h0b, 6'h00, 6'b110100, 1'b0);
    dec(6'h04, 6'h00, 6'b110010, 1'b1);
    dec(6'h05, 6'h00, 6'b110000, 1'b1);
    dec(6'h06, 6'h00, 6'b111100, 1'b1);
    dec(6'h07, 6'h00, 6'b111110, 1'b1);
    dec(6'h01, 6'h00, 6'b111010, 1'b1);
    dec(6'h3f, 6'h21, 6'b000000, 1'b1);

    chk("queue empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
